flog_sched: RTL and testbench

Round-robin scheduler that shares one non-pipelined bfloat16 log2 unit (top_top) between N_REQ requesters. It accepts one operand per valid/ready handshake and sequences the unit exactly as the unit requires: a reset pulse, then a held valid until the unit's valid_o. It returns each result tagged with the requester ID, and substitutes a quiet NaN when the unit fails to answer within TIMEOUT cycles. It sits between the requester-side logic and the single top_top instance.

---
 rtl/flog_pkg.sv | 23 ++
 rtl/flog_rr_arbiter.sv | 33 +++
 rtl/flog_sched.sv | 123 ++++++++++++
 tb/tb_flog_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flog_pkg.sv
// Shared types and widths for the bfloat16 log2 unit and its scheduler.
package flog_pkg;

  localparam int S_WIDTH     = 1;
  localparam int EXP_WIDTH   = 8;
  localparam int FRACT_WIDTH = 7;

  typedef enum logic [1:0] {IDLE, RST, ISSUE, RESP} flog_sched_state_t;

  typedef struct packed {
    logic [S_WIDTH-1:0]     sign;
    logic [EXP_WIDTH-1:0]   exp;
    logic [FRACT_WIDTH-1:0] fract;
  } flog_op_t;

  // Quiet NaN: positive, exponent all ones, fraction MSB set.
  localparam flog_op_t FLOG_QNAN = '{
    sign:  '0,
    exp:   '1,
    fract: {1'b1, {(FRACT_WIDTH-1){1'b0}}}
  };

endpackage

// File: rtl/flog_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or above ptr, wrapping.
module flog_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  int w_k;

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = int'(i_ptr) + i;
      if (w_k >= N_REQ) w_k = w_k - N_REQ;
      if (i_en && !o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = ID_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/flog_sched.sv
// Round-robin front end sharing one non-pipelined log2 unit between N_REQ requesters.
module flog_sched
  import flog_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  input  logic [N_REQ-1:0][S_WIDTH-1:0]     req_sign_i,
  input  logic [N_REQ-1:0][EXP_WIDTH-1:0]   req_exp_i,
  input  logic [N_REQ-1:0][FRACT_WIDTH-1:0] req_fract_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [ID_W-1:0]                   rsp_id_o,
  output logic [S_WIDTH-1:0]                rsp_sign_o,
  output logic [EXP_WIDTH-1:0]              rsp_exp_o,
  output logic [FRACT_WIDTH-1:0]            rsp_fract_o,
  output logic                              rsp_timeout_o,
  output logic                              flog_rst_o,
  output logic                              flog_valid_o,
  output logic [S_WIDTH-1:0]                flog_sign_o,
  output logic [EXP_WIDTH-1:0]              flog_exp_o,
  output logic [FRACT_WIDTH-1:0]            flog_fract_o,
  input  logic                              flog_valid_i,
  input  logic [S_WIDTH-1:0]                flog_s_res_i,
  input  logic [EXP_WIDTH-1:0]              flog_e_res_i,
  input  logic [FRACT_WIDTH-1:0]            flog_f_res_i
);

  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  flog_sched_state_t r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic [ID_W-1:0]   r_id;
  logic              r_tmo;
  flog_op_t          r_op;
  flog_op_t          r_res;

  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_idx;
  logic              w_any;
  logic [ID_W-1:0]   w_ptr_nxt;

  flog_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .i_en  (r_state == IDLE),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Grant is a valid requester, so the ready bit alone marks the handshake.
  assign req_ready_o = w_gnt;
  assign w_ptr_nxt   = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  // Unit is held in reset whenever it is not actively computing.
  assign flog_rst_o    = (r_state != ISSUE);
  assign flog_valid_o  = (r_state == ISSUE);
  assign flog_sign_o   = r_op.sign;
  assign flog_exp_o    = r_op.exp;
  assign flog_fract_o  = r_op.fract;

  assign rsp_valid_o   = (r_state == RESP);
  assign rsp_id_o      = r_id;
  assign rsp_sign_o    = r_res.sign;
  assign rsp_exp_o     = r_res.exp;
  assign rsp_fract_o   = r_res.fract;
  assign rsp_timeout_o = r_tmo;

  // Sequencer: accept -> reset pulse -> held issue -> response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_tmo   <= 1'b0;
      r_op    <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_op    <= '{sign: req_sign_i[w_idx], exp: req_exp_i[w_idx],
                       fract: req_fract_i[w_idx]};
          r_id    <= w_idx;
          r_ptr   <= w_ptr_nxt;
          r_cnt   <= '0;
          r_state <= RST;
        end
        RST: if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
          r_cnt   <= '0;
          r_state <= ISSUE;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
        end
        ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          // A real answer wins over a timeout landing in the same cycle.
          if (flog_valid_i) begin
            r_res   <= '{sign: flog_s_res_i, exp: flog_e_res_i, fract: flog_f_res_i};
            r_tmo   <= 1'b0;
            r_state <= RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_res   <= FLOG_QNAN;
            r_tmo   <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: if (rsp_ready_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flog_sched.sv
// Randomized bench for flog_sched with a behavioural log2 unit and a transaction-level model.
module tb_flog_sched;
  import flog_pkg::*;

  localparam int N  = 4;
  localparam int RC = 2;
  localparam int TO = 64;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]                  req_valid_i, req_ready_o;
  logic [N-1:0][S_WIDTH-1:0]     req_sign_i;
  logic [N-1:0][EXP_WIDTH-1:0]   req_exp_i;
  logic [N-1:0][FRACT_WIDTH-1:0] req_fract_i;
  logic                          rsp_valid_o, rsp_ready_i, rsp_timeout_o;
  logic [IW-1:0]                 rsp_id_o;
  logic [S_WIDTH-1:0]            rsp_sign_o, flog_sign_o, flog_s_res_i;
  logic [EXP_WIDTH-1:0]          rsp_exp_o, flog_exp_o, flog_e_res_i;
  logic [FRACT_WIDTH-1:0]        rsp_fract_o, flog_fract_o, flog_f_res_i;
  logic                          flog_rst_o, flog_valid_o, flog_valid_i;

  flog_sched #(.N_REQ(N), .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_sign_i(req_sign_i), .req_exp_i(req_exp_i), .req_fract_i(req_fract_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_sign_o(rsp_sign_o), .rsp_exp_o(rsp_exp_o), .rsp_fract_o(rsp_fract_o),
    .rsp_timeout_o(rsp_timeout_o),
    .flog_rst_o(flog_rst_o), .flog_valid_o(flog_valid_o),
    .flog_sign_o(flog_sign_o), .flog_exp_o(flog_exp_o), .flog_fract_o(flog_fract_o),
    .flog_valid_i(flog_valid_i), .flog_s_res_i(flog_s_res_i),
    .flog_e_res_i(flog_e_res_i), .flog_f_res_i(flog_f_res_i)
  );

  // Stand-in log2 unit: any fixed operand->result map serves as the reference.
  function automatic flog_op_t ufn(flog_op_t a);
    flog_op_t r;
    r.sign  = ~a.sign;
    r.exp   = a.exp ^ 8'hA5;
    r.fract = a.fract + 7'd3;
    return r;
  endfunction

  // Unit raises valid after seeing valid_i on `lat` edges; it never answers when dead.
  int       lat  = 5;
  bit       dead = 1'b0;
  int       u_cnt;
  logic     u_v;
  flog_op_t u_res;
  assign flog_valid_i = u_v;
  assign flog_s_res_i = u_res.sign;
  assign flog_e_res_i = u_res.exp;
  assign flog_f_res_i = u_res.fract;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_v <= 1'b0; u_cnt <= 0; u_res <= '0;
    end else if (flog_rst_o) begin
      u_v <= 1'b0; u_cnt <= 0;
    end else if (flog_valid_o && !u_v && !dead) begin
      if (u_cnt == lat - 1) begin
        u_v   <= 1'b1;
        u_res <= ufn('{sign: flog_sign_o, exp: flog_exp_o, fract: flog_fract_o});
      end
      u_cnt <= u_cnt + 1;
    end
  end

  // Requester side and transaction model.
  bit       pend [N];
  flog_op_t pop_ [N];
  bit       busy;
  int       mptr, nrsp, rstc, vc, e_id, e_lat;
  bit       e_tmo;
  flog_op_t e_op, e_res;
  int       ord[$];
  int       total = 0;
  int       bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int mgrant(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic flog_op_t rnd_op();
    flog_op_t o;
    o.sign = S_WIDTH'($urandom); o.exp = EXP_WIDTH'($urandom); o.fract = FRACT_WIDTH'($urandom);
    return o;
  endfunction

  task automatic drive(input bit rr);
    rsp_ready_i = rr;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = pend[i];
      req_sign_i[i]  = pop_[i].sign;
      req_exp_i[i]   = pop_[i].exp;
      req_fract_i[i] = pop_[i].fract;
    end
  endtask

  // One cycle: drive at negedge, check, advance model at posedge, return at next negedge.
  task automatic step(input bit rr, input bit refill);
    int g;
    bit rh;
    drive(rr);
    #1;
    g = busy ? -1 : mgrant(req_valid_i, mptr);
    chk("ready", req_ready_o, (g < 0) ? 0 : (1 << g));
    chk("rst_vs_vld", flog_rst_o, !flog_valid_o);
    if (!busy) chk("rsp_spurious", rsp_valid_o, 0);
    if (busy && !rsp_valid_o) begin
      if (flog_valid_o) begin
        vc++;
        chk("issue_op", {flog_sign_o, flog_exp_o, flog_fract_o}, e_op);
      end else if (vc == 0) rstc++;
    end
    if (busy && rsp_valid_o) begin
      chk("rsp_id", rsp_id_o, e_id);
      chk("rsp_res", {rsp_sign_o, rsp_exp_o, rsp_fract_o}, e_res);
      chk("rsp_tmo", rsp_timeout_o, e_tmo);
      chk("resp_flrst", flog_rst_o, 1);
    end
    rh = busy && rsp_valid_o && rr;
    if (rh) begin
      chk("rst_cycles", rstc, RC);
      chk("issue_cycles", vc, e_lat);
    end
    @(posedge clk);
    if (rh) begin busy = 1'b0; nrsp++; end
    if (g >= 0) begin
      busy  = 1'b1;
      e_id  = g;
      e_op  = pop_[g];
      e_tmo = dead;
      e_res = dead ? FLOG_QNAN : ufn(pop_[g]);
      e_lat = dead ? TO : lat + 1;
      rstc  = 0; vc = 0;
      mptr  = (g + 1) % N;
      ord.push_back(g);
      pend[g] = refill;
      if (refill) pop_[g] = rnd_op();
    end
    @(negedge clk);
  endtask

  task automatic run(input int cnt, input int bound, input bit rand_rr,
                     input bit refill, input bit rand_req);
    int tgt, cyc;
    tgt = nrsp + cnt;
    cyc = 0;
    while (nrsp < tgt && cyc < bound) begin
      if (rand_req)
        for (int i = 0; i < N; i++)
          if (!pend[i] && ($urandom % 4 == 0)) begin pend[i] = 1'b1; pop_[i] = rnd_op(); end
      if (!busy && rand_req) lat = $urandom_range(1, 6);
      step(rand_rr ? ($urandom % 3 != 0) : 1'b1, refill);
      cyc++;
    end
    chk("drain", nrsp, tgt);
  endtask

  // Async reset mid-cycle; outputs must fall to reset values at once.
  task automatic reset_chk();
    rst = 1'b0;
    drive(1'b0);
    #1;
    chk("r_rsp_valid", rsp_valid_o, 0);
    chk("r_rsp_fields", {rsp_id_o, rsp_sign_o, rsp_exp_o, rsp_fract_o, rsp_timeout_o}, 0);
    chk("r_flog_valid", flog_valid_o, 0);
    chk("r_flog_rst", flog_rst_o, 1);
    chk("r_flog_op", {flog_sign_o, flog_exp_o, flog_fract_o}, 0);
    chk("r_ready", req_ready_o,
        (mgrant(req_valid_i, 0) < 0) ? 0 : (1 << mgrant(req_valid_i, 0)));
    busy = 1'b0; mptr = 0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int c;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pop_[i] = '0; end
    drive(1'b1);
    busy = 1'b0; mptr = 0; nrsp = 0;
    @(negedge clk);
    reset_chk();

    // Single request from requester 2.
    lat = 5;
    pend[2] = 1'b1; pop_[2] = '{sign: 1'b0, exp: 8'd143, fract: 7'b1111010};
    run(1, 40, 1'b0, 1'b0, 1'b0);

    // All requesters continuously valid from ptr = 0.
    reset_chk();
    ord.delete();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pop_[i] = rnd_op(); end
    run(8, 200, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) chk("rr_order", ord[i], i % N);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;

    // Dead unit -> timeout qNaN, then normal service.
    dead = 1'b1;
    pend[1] = 1'b1; pop_[1] = rnd_op();
    run(1, 120, 1'b0, 1'b0, 1'b0);
    dead = 1'b0;
    pend[3] = 1'b1; pop_[3] = rnd_op();
    run(1, 40, 1'b0, 1'b0, 1'b0);

    // Consumer stalls 10 cycles in RESP while others wait.
    pend[0] = 1'b1; pop_[0] = rnd_op();
    c = 0;
    while (!(busy && rsp_valid_o) && c < 40) begin step(1'b0, 1'b0); c++; end
    chk("stall_reached", rsp_valid_o, 1);
    pend[2] = 1'b1; pop_[2] = rnd_op();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    run(2, 60, 1'b0, 1'b0, 1'b0);

    // Reset during ISSUE; requester 0 must win afterwards.
    lat = 8;
    pend[1] = 1'b1; pop_[1] = rnd_op();
    c = 0;
    while (!flog_valid_o && c < 40) begin step(1'b1, 1'b0); c++; end
    chk("issue_reached", flog_valid_o, 1);
    pend[0] = 1'b1; pop_[0] = rnd_op();
    pend[3] = 1'b1; pop_[3] = rnd_op();
    reset_chk();
    ord.delete();
    run(2, 80, 1'b0, 1'b0, 1'b0);
    chk("post_rst_first", ord[0], 0);

    // Operand sweep from requester 1: every exponent, every fraction.
    for (int k = 0; k < 256 + 128; k++) begin
      pend[1] = 1'b1;
      pop_[1] = rnd_op();
      if (k < 256) pop_[1].exp = EXP_WIDTH'(k);
      else         pop_[1].fract = FRACT_WIDTH'(k - 256);
      lat = $urandom_range(1, 6);
      run(1, 40, 1'b0, 1'b0, 1'b0);
    end

    // Mixed random traffic with consumer backpressure.
    run(300, 20000, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
